// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the 16-bit CPU datapath.
//   DATA_W     default datapath width
//   REG_N      default architectural register count
//   reg_addr_t register index for the default register file
//   word_t     datapath word
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam int REG_N  = 8;

  typedef logic [$clog2(REG_N)-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]        word_t;

  // Register index 0 is hardwired when the zero-register option is on.
  function automatic logic is_zero_reg(input int unsigned addr, input bit zero_r0);
    return zero_r0 && (addr == 0);
  endfunction
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: bundle of the register file's write, read and reserve signals.
//   master: decode/writeback side (drives we/waddr/wdata, read addresses,
//           rsv_en/rsv_addr; receives rdata_*, busy_*, any_busy)
//   slave : the register file itself
interface reg_file_if #(
  parameter int WIDTH = cpu_pkg::DATA_W,
  parameter int AW    = $clog2(cpu_pkg::REG_N)
);
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr_a;
  logic [WIDTH-1:0] rdata_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_b;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             busy_a;
  logic             busy_b;
  logic             any_busy;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b, rsv_en, rsv_addr,
    input  rdata_a, rdata_b, busy_a, busy_b, any_busy
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b, rsv_en, rsv_addr,
    output rdata_a, rdata_b, busy_a, busy_b, any_busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits for RAW hazard stalls.
//   clk, rst           clock, synchronous active-high reset
//   we, waddr          writeback release (clears pending)
//   rsv_en, rsv_addr   decode reserve (sets pending; wins over release)
//   raddr_a/b          lookup addresses
//   busy_a/b           pending bit of the looked-up register
//   any_busy           OR of all pending bits
// Macro REGFILE_BYPASS_EN: a register being released this cycle reads
// not-busy unless it is re-reserved in the same cycle.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREGS   = REG_N,
  parameter bit ZERO_R0 = 1'b1,
  parameter int AW      = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          rsv_en,
  input  logic [AW-1:0] rsv_addr,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic          busy_a,
  output logic          busy_b,
  output logic          any_busy
);
  logic [NREGS-1:0] pending_q, pending_d;
  logic             wr_ok, rsv_ok;

  assign wr_ok  = we     && !is_zero_reg(32'(waddr), ZERO_R0);
  assign rsv_ok = rsv_en && !is_zero_reg(32'(rsv_addr), ZERO_R0);

  always_comb begin
    pending_d = pending_q;
    if (wr_ok)  pending_d[waddr]    = 1'b0;
    // Reserve applied last: it belongs to the younger instruction.
    if (rsv_ok) pending_d[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  always_comb begin
    busy_a = pending_q[raddr_a];
    busy_b = pending_q[raddr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && raddr_a == waddr) busy_a = rsv_ok && (rsv_addr == waddr);
    if (wr_ok && raddr_b == waddr) busy_b = rsv_ok && (rsv_addr == waddr);
`endif
  end

  assign any_busy = |pending_q;
endmodule

// File: rtl/reg_file.sv
// reg_file: NREGS x WIDTH register file, one sync write port, two async
// read ports, plus a pending scoreboard for issue-stage RAW stalls.
//   clk, rst  clock, synchronous active-high reset (clears data + pending)
//   bus       reg_file_if.slave: we/waddr/wdata, raddr_a/b -> rdata_a/b,
//             rsv_en/rsv_addr, busy_a/b, any_busy
// Macro REGFILE_BYPASS_EN: forwards wdata to a read port addressing the
// register being written in the same cycle.
module reg_file
  import cpu_pkg::*;
#(
  parameter int WIDTH   = DATA_W,
  parameter int NREGS   = REG_N,
  parameter bit ZERO_R0 = 1'b1,
  parameter int AW      = $clog2(NREGS)
) (
  input  logic        clk,
  input  logic        rst,
  reg_file_if.slave   bus
);
  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic                        wr_ok;

  assign wr_ok = bus.we && !is_zero_reg(32'(bus.waddr), ZERO_R0);

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[bus.waddr] = bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  // Read path is address mux only; R0 is masked rather than relying on
  // its flop staying zero, so it folds away when ZERO_R0 is set.
  always_comb begin
    bus.rdata_a = is_zero_reg(32'(bus.raddr_a), ZERO_R0) ? '0 : regs_q[bus.raddr_a];
    bus.rdata_b = is_zero_reg(32'(bus.raddr_b), ZERO_R0) ? '0 : regs_q[bus.raddr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && bus.raddr_a == bus.waddr) bus.rdata_a = bus.wdata;
    if (wr_ok && bus.raddr_b == bus.waddr) bus.rdata_b = bus.wdata;
`endif
  end

  regfile_scoreboard #(
    .NREGS   (NREGS),
    .ZERO_R0 (ZERO_R0),
    .AW      (AW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .we       (bus.we),
    .waddr    (bus.waddr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .raddr_a  (bus.raddr_a),
    .raddr_b  (bus.raddr_b),
    .busy_a   (bus.busy_a),
    .busy_b   (bus.busy_b),
    .any_busy (bus.any_busy)
  );
endmodule
